csr_machine: RTL and testbench

CSR_MACHINE -- requirements
Module: csr_machine

---
 rtl/csr_machine.sv | 216 +++++++++++++++++++++
 tb/tb_csr_machine.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_machine.sv
// Machine-mode CSR file for a small RV32IM core: counters, interrupt pending/enable,
// trap entry with optional vectoring, and mret handling.
module csr_machine #(
    parameter int          NUM_HPM  = 4,
    parameter int          NUM_LIRQ = 4,
    parameter logic [31:0] HART_ID  = 32'd0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                crden,
    input  logic [11:0]         craddr,
    input  logic                cwren,
    input  logic [11:0]         cwaddr,
    input  logic [31:0]         cwdata,
    output logic [31:0]         cdata,
    output logic                illegal,
    input  logic                valid,
    input  logic [NUM_HPM-1:0]  hpm_evt,
    input  logic                exception,
    input  logic [4:0]          ecause,
    input  logic [31:0]         epc,
    input  logic [31:0]         etval,
    input  logic                mret,
    input  logic                meip,
    input  logic                mtip,
    input  logic                msip,
    input  logic [NUM_LIRQ-1:0] lirq,
    output logic                trap,
    output logic [31:0]         trap_pc,
    output logic                mret_out,
    output logic [31:0]         mepc_out
);

    localparam int          NCNT      = 3 + NUM_HPM;
    localparam logic [31:0] MISA_VAL  = 32'h4000_1100;
    localparam logic [31:0] IRQ_MASK  = 32'h0000_0888 | (((32'd1 << NUM_LIRQ) - 32'd1) << 16);
    localparam logic [63:0] CNT_ALL   = (64'd1 << NCNT) - 64'd1;
    localparam logic [31:0] CINH_MASK = CNT_ALL[31:0] & ~32'h0000_0002;

    logic        status_mie_q, status_mie_d, status_mpie_q, status_mpie_d;
    logic [31:0] mie_q, mie_d, mip_q, mip_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d, mcinh_q, mcinh_d;
    logic [63:0] cnt_q [NCNT];
    logic [63:0] cnt_d [NCNT];
    logic        trap_q, trap_d, mret_q, mret_d;

    logic [31:0]     mstatus_rd, rd_val, pend;
    logic            rd_hit, wr_hit, wr_ok, int_req, take_trap;
    logic [4:0]      int_cause;
    logic [NCNT-1:0] cnt_en;
    logic [31:0]     base;

    assign mstatus_rd = {19'b0, 2'b11, 3'b0, status_mpie_q, 3'b0, status_mie_q, 3'b0};

    always_comb begin
        rd_hit = 1'b1;
        rd_val = '0;
        case (craddr)
            12'h300: rd_val = mstatus_rd;
            12'h301: rd_val = MISA_VAL;
            12'h304: rd_val = mie_q;
            12'h305: rd_val = mtvec_q;
            12'h320: rd_val = mcinh_q;
            12'h340: rd_val = mscratch_q;
            12'h341: rd_val = mepc_q;
            12'h342: rd_val = mcause_q;
            12'h343: rd_val = mtval_q;
            12'h344: rd_val = mip_q;
            12'hF14: rd_val = HART_ID;
            default: begin
                rd_hit = 1'b0;
                for (int n = 0; n < NCNT; n++) begin
                    if (n != 1 && craddr == 12'hB00 + 12'(n)) begin
                        rd_hit = 1'b1;
                        rd_val = cnt_q[n][31:0];
                    end
                    if (n != 1 && craddr == 12'hB80 + 12'(n)) begin
                        rd_hit = 1'b1;
                        rd_val = cnt_q[n][63:32];
                    end
                end
            end
        endcase
    end

    // misa and mhartid are read-only, so they are absent from the write decode
    always_comb begin
        wr_hit = 1'b0;
        case (cwaddr)
            12'h300, 12'h304, 12'h305, 12'h320, 12'h340,
            12'h341, 12'h342, 12'h343, 12'h344: wr_hit = 1'b1;
            default: begin
                for (int n = 0; n < NCNT; n++) begin
                    if (n != 1 && (cwaddr == 12'hB00 + 12'(n) || cwaddr == 12'hB80 + 12'(n)))
                        wr_hit = 1'b1;
                end
            end
        endcase
    end

    assign wr_ok   = cwren & wr_hit;
    assign illegal = (crden & ~rd_hit) | (cwren & ~wr_hit);
    assign cdata   = (crden & rd_hit) ? rd_val : 32'd0;

    // Interrupt arbitration: MEI > MSI > MTI > lowest-numbered local line
    always_comb begin
        pend      = mie_q & mip_q;
        int_req   = 1'b1;
        int_cause = 5'd0;
        if (pend[11])      int_cause = 5'd11;
        else if (pend[3])  int_cause = 5'd3;
        else if (pend[7])  int_cause = 5'd7;
        else begin
            int_req = 1'b0;
            for (int i = NUM_LIRQ - 1; i >= 0; i--) begin
                if (pend[16 + i]) begin
                    int_req   = 1'b1;
                    int_cause = 5'(16 + i);
                end
            end
        end
    end

    assign take_trap = exception | (status_mie_q & valid & int_req);
    assign cnt_en    = {hpm_evt, valid, 1'b0, 1'b1} & ~mcinh_q[NCNT-1:0];

    always_comb begin
        status_mie_d  = status_mie_q;
        status_mpie_d = status_mpie_q;
        mie_d         = mie_q;
        mtvec_d       = mtvec_q;
        mscratch_d    = mscratch_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
        mtval_d       = mtval_q;
        mcinh_d       = mcinh_q;
        mip_d         = ({31'b0, msip} << 3) | ({31'b0, mtip} << 7) | ({31'b0, meip} << 11)
                        | (32'(lirq) << 16);
        trap_d        = take_trap;
        mret_d        = mret & ~take_trap;

        if (wr_ok) begin
            case (cwaddr)
                12'h300: begin
                    status_mie_d  = cwdata[3];
                    status_mpie_d = cwdata[7];
                end
                12'h304: mie_d      = cwdata & IRQ_MASK;
                12'h305: mtvec_d    = cwdata & 32'hFFFF_FFFD;
                12'h320: mcinh_d    = cwdata & CINH_MASK;
                12'h340: mscratch_d = cwdata;
                12'h341: mepc_d     = cwdata & 32'hFFFF_FFFC;
                12'h342: mcause_d   = cwdata;
                12'h343: mtval_d    = cwdata;
                default: ;
            endcase
        end

        // Trap/mret take precedence over a CSR write to the same fields
        if (take_trap) begin
            status_mpie_d = status_mie_q;
            status_mie_d  = 1'b0;
            mepc_d        = epc & 32'hFFFF_FFFC;
            mtval_d       = exception ? etval : 32'd0;
            mcause_d      = exception ? {27'b0, ecause} : {1'b1, 26'b0, int_cause};
        end else if (mret) begin
            status_mie_d  = status_mpie_q;
            status_mpie_d = 1'b1;
        end

        for (int n = 0; n < NCNT; n++) begin
            cnt_d[n] = cnt_q[n] + {63'b0, cnt_en[n]};
            if (wr_ok && cwaddr == 12'hB00 + 12'(n)) cnt_d[n][31:0]  = cwdata;
            if (wr_ok && cwaddr == 12'hB80 + 12'(n)) cnt_d[n][63:32] = cwdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_mie_q  <= 1'b0;
            status_mpie_q <= 1'b0;
            mie_q         <= '0;
            mip_q         <= '0;
            mtvec_q       <= '0;
            mscratch_q    <= '0;
            mepc_q        <= '0;
            mcause_q      <= '0;
            mtval_q       <= '0;
            mcinh_q       <= '0;
            trap_q        <= 1'b0;
            mret_q        <= 1'b0;
            for (int n = 0; n < NCNT; n++) cnt_q[n] <= '0;
        end else begin
            status_mie_q  <= status_mie_d;
            status_mpie_q <= status_mpie_d;
            mie_q         <= mie_d;
            mip_q         <= mip_d;
            mtvec_q       <= mtvec_d;
            mscratch_q    <= mscratch_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            mtval_q       <= mtval_d;
            mcinh_q       <= mcinh_d;
            trap_q        <= trap_d;
            mret_q        <= mret_d;
            for (int n = 0; n < NCNT; n++) cnt_q[n] <= cnt_d[n];
        end
    end

    assign base     = {mtvec_q[31:2], 2'b00};
    assign trap_pc  = (mtvec_q[0] & mcause_q[31]) ? base + {25'b0, mcause_q[4:0], 2'b00} : base;
    assign trap     = trap_q;
    assign mret_out = mret_q;
    assign mepc_out = mepc_q;

endmodule

// File: tb/tb_csr_machine.sv
// Scoreboard bench for csr_machine: stimulus pushes expected responses into queues,
// a negedge monitor pops and compares whenever the DUT presents an access, trap or mret.
module tb_csr_machine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        crden = 1'b0, cwren = 1'b0;
    logic [11:0] craddr = '0, cwaddr = '0;
    logic [31:0] cwdata = '0;
    logic [31:0] cdata;
    logic        illegal;
    logic        valid = 1'b0;
    logic [3:0]  hpm_evt = '0;
    logic        exception = 1'b0;
    logic [4:0]  ecause = '0;
    logic [31:0] epc = '0, etval = '0;
    logic        mret = 1'b0;
    logic        meip = 1'b0, mtip = 1'b0, msip = 1'b0;
    logic [3:0]  lirq = '0;
    logic        trap, mret_out;
    logic [31:0] trap_pc, mepc_out;

    int checks = 0;
    int errors = 0;

    typedef struct { string name; logic [31:0] data; logic ill; } accT;
    typedef struct { string name; logic [31:0] pc; logic [31:0] mepc; } trapT;
    accT         accQ[$];
    trapT        trapQ[$];
    logic [31:0] mretQ[$];

    csr_machine #(.NUM_HPM(4), .NUM_LIRQ(4), .HART_ID(32'd0)) dut (
        .clk(clk), .rst(rst), .crden(crden), .craddr(craddr), .cwren(cwren),
        .cwaddr(cwaddr), .cwdata(cwdata), .cdata(cdata), .illegal(illegal),
        .valid(valid), .hpm_evt(hpm_evt), .exception(exception), .ecause(ecause),
        .epc(epc), .etval(etval), .mret(mret), .meip(meip), .mtip(mtip), .msip(msip),
        .lirq(lirq), .trap(trap), .trap_pc(trap_pc), .mret_out(mret_out),
        .mepc_out(mepc_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // Drive one cycle of CSR port activity just after the rising edge
    task automatic applyStimulus(input logic rd, input logic [11:0] ra, input logic wr,
                                 input logic [11:0] wa, input logic [31:0] wd,
                                 input logic [31:0] expData, input logic expIll);
        accT e;
        @(posedge clk);
        #1;
        crden  = rd;
        craddr = ra;
        cwren  = wr;
        cwaddr = wa;
        cwdata = wd;
        if (rd || wr) begin
            e.name = rd ? $sformatf("rd%03h", ra) : $sformatf("wr%03h", wa);
            e.data = expData;
            e.ill  = expIll;
            accQ.push_back(e);
        end
    endtask

    task automatic csrRead(input logic [11:0] a, input logic [31:0] exp, input logic ill = 1'b0);
        applyStimulus(1'b1, a, 1'b0, 12'h0, 32'h0, exp, ill);
    endtask

    task automatic csrWrite(input logic [11:0] a, input logic [31:0] d, input logic ill = 1'b0);
        applyStimulus(1'b0, 12'h0, 1'b1, a, d, 32'h0, ill);
    endtask

    task automatic nop();
        applyStimulus(1'b0, 12'h0, 1'b0, 12'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic expectTrap(input string name, input logic [31:0] pc, input logic [31:0] m);
        trapT t;
        t.name = name;
        t.pc   = pc;
        t.mepc = m;
        trapQ.push_back(t);
    endtask

    always @(negedge clk) begin
        if (crden || cwren) begin
            if (accQ.size() == 0) checkOutput("unexpected-access", 32'(accQ.size()), 32'd1);
            else begin
                accT e;
                e = accQ.pop_front();
                checkOutput({e.name, "-data"}, cdata, e.data);
                checkOutput({e.name, "-illegal"}, {31'b0, illegal}, {31'b0, e.ill});
            end
        end
        if (trap) begin
            if (trapQ.size() == 0) checkOutput("unexpected-trap", 32'(trapQ.size()), 32'd1);
            else begin
                trapT t;
                t = trapQ.pop_front();
                checkOutput({t.name, "-pc"}, trap_pc, t.pc);
                checkOutput({t.name, "-mepc"}, mepc_out, t.mepc);
            end
        end
        if (mret_out) begin
            if (mretQ.size() == 0) checkOutput("unexpected-mret", 32'(mretQ.size()), 32'd1);
            else checkOutput("mret-mepc", mepc_out, mretQ.pop_front());
        end
    end

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        csrRead(12'h300, 32'h0000_1800);
        csrRead(12'h341, 32'h0);
        csrRead(12'hB00, 32'h0);
        nop();
        rst = 1'b0;

        // Reset values and plain register access
        csrRead(12'h301, 32'h4000_1100);
        csrRead(12'hF14, 32'h0);
        csrRead(12'h305, 32'h0);
        csrRead(12'h304, 32'h0);
        csrRead(12'h342, 32'h0);
        csrRead(12'h320, 32'h0);
        csrRead(12'h7C0, 32'h0, 1'b1);
        csrRead(12'hB01, 32'h0, 1'b1);
        csrWrite(12'h301, 32'hFFFF_FFFF, 1'b1);
        csrWrite(12'hF14, 32'h1234_5678, 1'b1);
        csrRead(12'h301, 32'h4000_1100);
        csrRead(12'hF14, 32'h0);
        csrWrite(12'h340, 32'hDEAD_BEEF);
        csrRead(12'h340, 32'hDEAD_BEEF);
        csrWrite(12'h341, 32'h1234_5677);
        csrRead(12'h341, 32'h1234_5674);
        csrWrite(12'h305, 32'h0000_0103);
        csrRead(12'h305, 32'h0000_0101);
        csrWrite(12'h304, 32'hFFFF_FFFF);
        csrRead(12'h304, 32'h000F_0888);
        csrWrite(12'h344, 32'hFFFF_FFFF);
        csrRead(12'h344, 32'h0);
        csrWrite(12'h320, 32'hFFFF_FFFF);
        csrRead(12'h320, 32'h0000_007D);
        csrWrite(12'h320, 32'h0);
        csrWrite(12'h300, 32'h0000_0088);
        csrRead(12'h300, 32'h0000_1888);
        csrWrite(12'h300, 32'h0);

        // Vectored timer interrupt
        csrWrite(12'h305, 32'h0000_0101);
        csrWrite(12'h304, 32'h0000_0080);
        csrWrite(12'h300, 32'h0000_0008);
        nop(); mtip = 1'b1; valid = 1'b1; epc = 32'h2000; etval = 32'h55;
        expectTrap("trap-mti", 32'h0000_011C, 32'h2000);
        nop();
        nop(); mtip = 1'b0; valid = 1'b0;
        csrRead(12'h342, 32'h8000_0007);
        csrRead(12'h300, 32'h0000_1880);
        csrRead(12'h343, 32'h0);
        nop(); mret = 1'b1; mretQ.push_back(32'h2000);
        nop(); mret = 1'b0;
        csrRead(12'h300, 32'h0000_1888);

        // Exception beats a pending external interrupt and a same-cycle mret
        csrWrite(12'h304, 32'h0000_0880);
        nop(); meip = 1'b1;
        nop(); exception = 1'b1; ecause = 5'd2; epc = 32'h3000; etval = 32'hBAD;
        mret = 1'b1; valid = 1'b1;
        expectTrap("trap-exc", 32'h0000_0100, 32'h3000);
        nop(); exception = 1'b0; mret = 1'b0; valid = 1'b0; meip = 1'b0;
        csrRead(12'h342, 32'h0000_0002);
        csrRead(12'h343, 32'h0000_0BAD);
        csrRead(12'h300, 32'h0000_1880);

        // External beats timer when both pend
        csrWrite(12'h300, 32'h0000_0008);
        nop(); meip = 1'b1; mtip = 1'b1; valid = 1'b1; epc = 32'h4000;
        expectTrap("trap-mei", 32'h0000_012C, 32'h4000);
        nop();
        nop(); meip = 1'b0; mtip = 1'b0; valid = 1'b0;
        csrRead(12'h342, 32'h8000_000B);

        // Lowest local line wins; trap overrides a same-cycle mstatus write
        csrWrite(12'h304, 32'h000F_0000);
        csrWrite(12'h300, 32'h0000_0008);
        nop(); lirq = 4'b1100; valid = 1'b1; epc = 32'h5000;
        expectTrap("trap-lirq", 32'h0000_0148, 32'h5000);
        csrWrite(12'h300, 32'h0000_0088);
        nop(); lirq = 4'b0000; valid = 1'b0;
        csrRead(12'h342, 32'h8000_0012);
        csrRead(12'h300, 32'h0000_1880);

        // mcycle wrap, and write-vs-increment on each half
        csrWrite(12'hB80, 32'hFFFF_FFFF);
        csrWrite(12'hB00, 32'hFFFF_FFFF);
        csrRead(12'hB80, 32'hFFFF_FFFF);
        csrRead(12'hB00, 32'h0);
        csrRead(12'hB80, 32'h0);
        csrWrite(12'hB00, 32'hFFFF_FFFF);
        csrWrite(12'hB80, 32'h0000_0005);
        csrRead(12'hB80, 32'h0000_0005);
        csrRead(12'hB00, 32'h0000_0001);
        csrWrite(12'hB00, 32'hFFFF_FFFF);
        csrWrite(12'hB00, 32'h0000_0010);
        csrRead(12'hB80, 32'h0000_0006);

        // mhpmcounter3 inhibit
        csrWrite(12'h320, 32'h0000_0008);
        for (int i = 0; i < 10; i++) begin
            nop(); hpm_evt = 4'b0001;
            nop(); hpm_evt = 4'b0000;
        end
        csrRead(12'hB03, 32'h0);
        csrWrite(12'h320, 32'h0);
        for (int i = 0; i < 3; i++) begin
            nop(); hpm_evt = 4'b0001;
            nop(); hpm_evt = 4'b0000;
        end
        csrRead(12'hB03, 32'h0000_0003);
        csrRead(12'hB83, 32'h0);

        // Asynchronous reset just after a trap edge
        csrWrite(12'h304, 32'h0000_0008);
        csrWrite(12'h300, 32'h0000_0008);
        nop(); msip = 1'b1; valid = 1'b1; epc = 32'h6000;
        nop();
        @(posedge clk);
        #1;
        checkOutput("pre-reset-trap", {31'b0, trap}, 32'd1);
        checkOutput("pre-reset-trap-pc", trap_pc, 32'h0000_010C);
        #1 rst = 1'b1;
        #1;
        checkOutput("async-trap", {31'b0, trap}, 32'd0);
        checkOutput("async-trap-pc", trap_pc, 32'd0);
        checkOutput("async-mepc", mepc_out, 32'd0);
        msip = 1'b0; valid = 1'b0;
        csrRead(12'h300, 32'h0000_1800);
        csrRead(12'h304, 32'h0);
        csrRead(12'h305, 32'h0);
        csrRead(12'h342, 32'h0);
        csrRead(12'h340, 32'h0);
        csrRead(12'hB03, 32'h0);
        csrRead(12'hB00, 32'h0);
        csrRead(12'h344, 32'h0);
        nop();
        rst = 1'b0;
        repeat (3) nop();

        checkOutput("pending-accesses", 32'(accQ.size()), 32'd0);
        checkOutput("pending-traps", 32'(trapQ.size()), 32'd0);
        checkOutput("pending-mrets", 32'(mretQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
